fetch_mem_arbiter: RTL
======================

Name: fetch_mem_arbiter

Overview:
- Shares one multi-cycle memory port between the instruction-fetch requester (IF stage, read-only) and the data requester (MEM stage, read/write).
- Sequences each access with a level handshake, returns read data with one-cycle valid pulses, and generates the stall signals consumed by the pipeline (IF stall, mem stall).
- Handles fetch flushes on branch/jump and guarantees that fetch is not starved.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive data grants made while a fetch is pending, after which the next grant is forced to fetch.
- TIMEOUT, 1023, number of busy cycles without mem_ack_i before the access is aborted and err_o is set.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- i_req_i  in  1  fetch request (level, held until i_valid_o or flush)
- i_addr_i  in  ADDR_W  fetch PC
- i_flush_i  in  1  branch-taken or jump; discards the in-flight or pending fetch result
- i_valid_o  out  1  one-cycle pulse, fetch data valid
- i_rdata_o  out  DATA_W  fetched instruction
- i_stall_o  out  1  IF must hold PC and IF/ID register
- d_req_i  in  1  data request (level, held until d_valid_o)
- d_we_i  in  1  1 = write
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_valid_o  out  1  one-cycle pulse, access complete
- d_rdata_o  out  DATA_W  load data
- d_stall_o  out  1  pipeline-wide mem stall
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data
- mem_ack_i  in  1  one-cycle completion from memory
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset: state is IDLE. All outputs are 0, including the rdata registers and err_o. starve_cnt, timeout count and drop flag are cleared. Reset mid-access drops mem_enable_o on the same edge, and any later mem_ack_i is ignored.
- States:
  - IDLE: choose a grant, or stay in IDLE.
  - I_BUSY: a fetch access is in flight.
  - D_BUSY: a data access is in flight.
  - RESP: exactly one cycle, no new grant. This lets the requester see its valid pulse and drop its request.
- Grant in IDLE, at most one grant per cycle:
  - If d_req_i=1 and starve_cnt < STARVE_LIMIT, go to D_BUSY.
  - Otherwise, if i_req_i=1 and i_flush_i=0, go to I_BUSY.
  - Otherwise, if d_req_i=1 (fetch not eligible), go to D_BUSY.
- Starvation count:
  - starve_cnt increments on a data grant while i_req_i=1, saturating at STARVE_LIMIT.
  - It clears on any fetch grant, and whenever i_req_i=0.
  - With the count at STARVE_LIMIT and both requests high, the grant goes to fetch.
- Issue: on grant, addr/we/wdata are latched into the mem_* registers, and mem_enable_o=1 from the next cycle. mem_enable_o stays high until the cycle in which mem_ack_i=1 is sampled, and is deasserted on that edge. mem_write_o=0 for fetch.
- Completion, on mem_ack_i in a BUSY state:
  - mem_rdata_i is captured into i_rdata_o or d_rdata_o; writes leave d_rdata_o unchanged.
  - The matching valid is pulsed for the RESP cycle, then the state returns to IDLE.
  - Latency from grant to valid is N+1 cycles after the ack, where N = cycles until the ack arrives.
- mem_ack_i sampled in IDLE or RESP is ignored.
- Flush:
  - i_flush_i in I_BUSY sets the drop flag. The access completes normally, but i_valid_o is suppressed.
  - i_flush_i in RESP after a fetch suppresses that i_valid_o.
  - i_flush_i in IDLE blocks a fetch grant that cycle.
  - Flush has no effect on data accesses.
- Stalls, combinational from registered state:
  - d_stall_o = d_req_i & ~d_valid_o.
  - i_stall_o = (i_req_i & ~i_valid_o) | d_stall_o.
  - Both are 0 in reset.
- Timeout:
  - The busy counter counts cycles in a BUSY state.
  - When it reaches TIMEOUT: mem_enable_o drops, err_o is set (sticky), and the state goes to RESP with no valid pulse.
  - The requester remains stalled, and the next grant retries.
- Simultaneous ack and timeout in the same cycle: the ack wins.

Decomposition:
- Shared package arb_pkg holds:
  - the state enum (IDLE, I_BUSY, D_BUSY, RESP);
  - grant encoding constants;
  - the default STARVE_LIMIT and TIMEOUT values.
- One natural sub-module, arb_timeout_counter: a busy-cycle counter with load/clear and a terminal-count output.
- Grant logic and the FSM stay inline.

Test Plan:
- Single fetch, addr 0x40, mem acks after 3 cycles with 0x00A00093 → mem_enable_o high 3 cycles, i_valid_o pulses with i_rdata_o=0x00A00093, i_stall_o low the cycle after the pulse.
- i_req_i and d_req_i rise together, d_we_i=1, addr 0x100, wdata 0xDEADBEEF → data is granted first with mem_write_o=1, then fetch; no overlapping mem_enable_o.
- d_req_i continuous for 10 accesses with i_req_i held → fetch is granted after exactly 4 data grants (STARVE_LIMIT=4).
- i_flush_i pulsed while in I_BUSY → ack consumed, i_valid_o stays 0, FSM returns to IDLE, next fetch uses the new i_addr_i.
- mem_ack_i never arrives, TIMEOUT=8 → mem_enable_o drops after 8 busy cycles, err_o=1 stays high, request retried.
- rst_i asserted during D_BUSY → next cycle mem_enable_o=0, state IDLE, all valids and err_o 0; a late mem_ack_i produces no valid pulse.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and constants for the fetch/data memory arbiter:
//                FSM state enum, grant encodings, default limits and a
//                counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    // Grant decision encodings produced by the IDLE-state selector
    localparam logic [1:0] C_GNT_NONE  = 2'd0;
    localparam logic [1:0] C_GNT_FETCH = 2'd1;
    localparam logic [1:0] C_GNT_DATA  = 2'd2;

    // Default tuning values
    localparam int C_DEF_STARVE_LIMIT = 4;
    localparam int C_DEF_TIMEOUT      = 1023;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_timeout_counter
//  Description : Busy-cycle counter. Cleared (loaded with zero) while the
//                arbiter is not busy, counts each busy cycle, and flags the
//                TIMEOUT-th busy cycle as terminal.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_timeout_counter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = C_DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int              CW     = cnt_width(TIMEOUT);
    // Value held during the last permitted busy cycle (count starts at 0)
    localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count busy cycles; hold at the terminal value rather than wrapping
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_count <= '0;
        end else if (en_i && (r_count != C_LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tc_o = en_i && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/fetch_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_mem_arbiter
//  Description : Shares one multi-cycle memory port between the IF-stage fetch
//                requester and the MEM-stage data requester. Level handshake
//                in, one-cycle valid pulses out, pipeline stall generation,
//                fetch flush handling, anti-starvation for fetch and a
//                busy timeout with a sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = C_DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = C_DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Fetch requester
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_flush_i,
    output logic              i_valid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_stall_o,
    // Data requester
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_valid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_stall_o,
    // Memory port
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    // Status
    output logic              err_o
);

    localparam int              SC_W         = cnt_width(STARVE_LIMIT);
    localparam logic [SC_W-1:0] C_STARVE_MAX = SC_W'(STARVE_LIMIT);

    arb_state_e        r_state;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_valid;
    logic              r_d_valid;
    logic              r_err;
    logic              r_drop;
    logic [SC_W-1:0]   r_starve_cnt;

    logic [1:0]        w_grant;
    logic              w_busy;
    logic              w_tc;
    logic              w_data_turn;
    logic              w_fetch_ok;
    logic              w_i_valid;
    logic              w_d_stall;

    assign w_busy = (r_state == ST_I_BUSY) || (r_state == ST_D_BUSY);

    // Counter restarts from zero every time a new access begins
    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (~w_busy),
        .en_i  (w_busy),
        .tc_o  (w_tc)
    );

    // Grant selection: data first unless fetch has waited through STARVE_LIMIT data grants
    always_comb begin
        w_data_turn = d_req_i && (r_starve_cnt < C_STARVE_MAX);
        w_fetch_ok  = i_req_i && !i_flush_i;
        w_grant     = C_GNT_NONE;
        if (r_state == ST_IDLE) begin
            if (w_data_turn) begin
                w_grant = C_GNT_DATA;
            end else if (w_fetch_ok) begin
                w_grant = C_GNT_FETCH;
            end else if (d_req_i) begin
                w_grant = C_GNT_DATA;
            end
        end
    end

    // Count data grants made while fetch is waiting; any idle fetch request gap clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
        end else if (!i_req_i || (w_grant == C_GNT_FETCH)) begin
            r_starve_cnt <= '0;
        end else if ((w_grant == C_GNT_DATA) && (r_starve_cnt != C_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end
    end

    // Access sequencer: issue on grant, capture on ack, abort on timeout, one RESP turnaround
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
            r_err        <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant == C_GNT_DATA) begin
                        r_state      <= ST_D_BUSY;
                        r_mem_enable <= 1'b1;
                        r_mem_write  <= d_we_i;
                        r_mem_addr   <= d_addr_i;
                        r_mem_wdata  <= d_wdata_i;
                    end else if (w_grant == C_GNT_FETCH) begin
                        r_state      <= ST_I_BUSY;
                        r_mem_enable <= 1'b1;
                        r_mem_write  <= 1'b0;
                        r_mem_addr   <= i_addr_i;
                        r_mem_wdata  <= '0;
                    end
                end
                ST_I_BUSY: begin
                    // A flush anywhere in the access, including the ack cycle, kills the pulse
                    if (i_flush_i) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        r_mem_enable <= 1'b0;
                        r_i_rdata    <= mem_rdata_i;
                        r_i_valid    <= ~(r_drop | i_flush_i);
                        r_state      <= ST_RESP;
                    end else if (w_tc) begin
                        r_mem_enable <= 1'b0;
                        r_err        <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_D_BUSY: begin
                    if (mem_ack_i) begin
                        r_mem_enable <= 1'b0;
                        if (!r_mem_write) begin
                            r_d_rdata <= mem_rdata_i;
                        end
                        r_d_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end else if (w_tc) begin
                        r_mem_enable <= 1'b0;
                        r_err        <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the RESP cycle still hides the fetch result
    assign w_i_valid = r_i_valid & ~i_flush_i;
    assign w_d_stall = ~rst_i & d_req_i & ~r_d_valid;

    assign i_valid_o    = w_i_valid;
    assign i_rdata_o    = r_i_rdata;
    assign i_stall_o    = ~rst_i & ((i_req_i & ~w_i_valid) | w_d_stall);
    assign d_valid_o    = r_d_valid;
    assign d_rdata_o    = r_d_rdata;
    assign d_stall_o    = w_d_stall;
    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;
    assign err_o        = r_err;

endmodule
`default_nettype wire
